// File: rtl/quad_pkg.sv
// Shared defaults and helpers for the parametrised quadrature decoder.
// Saturation operates on a wide signed value so callers never overflow before clamping.
package quad_pkg;

  localparam int unsigned DefCntW       = 16;
  localparam int unsigned DefCpr        = 1496;
  localparam int unsigned DefSampleDiv  = 131072;
  localparam int unsigned DefDeltaW     = 16;
  localparam int unsigned DefVelW       = 16;
  localparam int unsigned DefScaleNum   = 29;
  localparam int unsigned DefScaleShift = 3;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) res = unsigned'(i + 1);
    end
    return res;
  endfunction

  function automatic logic signed [63:0] sat_s(input logic signed [63:0] value,
                                               input int unsigned width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (value > hi) return hi;
    else if (value < lo) return lo;
    else return value;
  endfunction

endpackage

// File: rtl/quad_decoder_vel_if.sv
// Encoder pins and decoded outputs of one axis; the decoder is the slave side.
interface quad_decoder_vel_if
  import quad_pkg::*;
#(
  parameter int unsigned CNT_W = DefCntW,
  parameter int unsigned VEL_W = DefVelW
);

  logic             quad_a;
  logic             quad_b;
  logic             quad_z;
  logic [CNT_W-1:0] pos;
  logic             dir;
  logic [VEL_W-1:0] vel;
  logic             vel_valid;
  logic             err;

  modport master (
    output quad_a, quad_b, quad_z,
    input  pos, dir, vel, vel_valid, err
  );

  modport slave (
    input  quad_a, quad_b, quad_z,
    output pos, dir, vel, vel_valid, err
  );

endinterface

// File: rtl/quad_edge_sync.sv
// Two-flop synchroniser plus one delay stage on A/B/Z, and x4 quadrature edge decode.
// Reset loads the live pin level into every stage so no phantom edge follows reset.
module quad_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic a_i,
  input  logic b_i,
  input  logic z_i,
  output logic step_o,
  output logic up_o,
  output logic illegal_o,
  output logic z_rise_o
);

  // Bit order {z, b, a}
  logic [2:0] raw;
  logic [2:0] s1_q, s1_d;
  logic [2:0] s2_q, s2_d;
  logic [2:0] dly_q, dly_d;
  logic [2:0] chg;

  assign raw = {z_i, b_i, a_i};

  always_comb begin
    s1_d  = raw;
    s2_d  = s1_q;
    dly_d = s2_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q  <= raw;
      s2_q  <= raw;
      dly_q <= raw;
    end else begin
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      dly_q <= dly_d;
    end
  end

  always_comb begin
    chg       = s2_q ^ dly_q;
    step_o    = chg[0] ^ chg[1];
    up_o      = s2_q[0] ^ dly_q[1];
    illegal_o = chg[0] & chg[1];
    z_rise_o  = s2_q[2] & ~dly_q[2];
  end

endmodule

// File: rtl/quad_decoder_vel.sv
// Quadrature decoder: modulo-CPR position, per-window signed scaled velocity, sticky error.
// The velocity window is a strobe on clk, never a derived clock.
module quad_decoder_vel
  import quad_pkg::*;
#(
  parameter int unsigned CNT_W       = DefCntW,
  parameter int unsigned CPR         = DefCpr,
  parameter int unsigned SAMPLE_DIV  = DefSampleDiv,
  parameter int unsigned DELTA_W     = DefDeltaW,
  parameter int unsigned VEL_W       = DefVelW,
  parameter int unsigned SCALE_NUM   = DefScaleNum,
  parameter int unsigned SCALE_SHIFT = DefScaleShift,
  parameter int unsigned IDX_EN      = 0
) (
  input logic               clk,
  input logic               rst,
  quad_decoder_vel_if.slave bus
);

  localparam int unsigned WinW  = clog2(SAMPLE_DIV);
  localparam int unsigned ProdW = DELTA_W + clog2(SCALE_NUM + 1) + 1;

  localparam logic [CNT_W-1:0] PosMax = CNT_W'(CPR - 1);
  localparam logic [WinW-1:0]  WinMax = WinW'(SAMPLE_DIV - 1);
  localparam logic signed [DELTA_W-1:0] DeltaMax = {1'b0, {(DELTA_W - 1){1'b1}}};
  localparam logic signed [DELTA_W-1:0] DeltaMin = {1'b1, {(DELTA_W - 2){1'b0}}, 1'b1};

  logic step, up, illegal, z_rise;

  quad_edge_sync u_edge_sync (
    .clk       (clk),
    .rst       (rst),
    .a_i       (bus.quad_a),
    .b_i       (bus.quad_b),
    .z_i       (bus.quad_z),
    .step_o    (step),
    .up_o      (up),
    .illegal_o (illegal),
    .z_rise_o  (z_rise)
  );

  logic [CNT_W-1:0]          pos_q, pos_d;
  logic                      dir_q, dir_d;
  logic                      err_q, err_d;
  logic [WinW-1:0]           win_q, win_d;
  logic signed [DELTA_W-1:0] delta_q, delta_d;
  logic signed [DELTA_W-1:0] delta_base;
  logic signed [VEL_W-1:0]   vel_q, vel_d;
  logic                      vel_valid_q, vel_valid_d;
  logic                      strobe;
  logic signed [ProdW-1:0]   prod;
  logic signed [ProdW-1:0]   shifted;

  // Position and direction; index has priority over a coincident step
  always_comb begin
    pos_d = pos_q;
    dir_d = dir_q;
    err_d = err_q | illegal;
    if (IDX_EN != 0 && z_rise) begin
      pos_d = '0;
    end else if (step) begin
      if (up) pos_d = (pos_q == PosMax) ? '0 : pos_q + 1'b1;
      else    pos_d = (pos_q == '0) ? PosMax : pos_q - 1'b1;
    end
    if (step) dir_d = up;
  end

  // Window accumulator; a step in the strobe cycle seeds the next window
  always_comb begin
    strobe     = (win_q == WinMax);
    win_d      = strobe ? '0 : win_q + 1'b1;
    delta_base = strobe ? '0 : delta_q;
    delta_d    = delta_base;
    if (step) begin
      if (up && delta_base != DeltaMax)       delta_d = delta_base + 1'b1;
      else if (!up && delta_base != DeltaMin) delta_d = delta_base - 1'b1;
    end
  end

  // Product is wide enough that only the final clamp can limit the result
  always_comb begin
    prod        = ProdW'(delta_q) * $signed(ProdW'(SCALE_NUM));
    shifted     = prod >>> SCALE_SHIFT;
    vel_d       = vel_q;
    vel_valid_d = 1'b0;
    if (strobe) begin
      vel_d       = VEL_W'(sat_s(64'(shifted), VEL_W));
      vel_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pos_q       <= '0;
      dir_q       <= 1'b0;
      err_q       <= 1'b0;
      win_q       <= '0;
      delta_q     <= '0;
      vel_q       <= '0;
      vel_valid_q <= 1'b0;
    end else begin
      pos_q       <= pos_d;
      dir_q       <= dir_d;
      err_q       <= err_d;
      win_q       <= win_d;
      delta_q     <= delta_d;
      vel_q       <= vel_d;
      vel_valid_q <= vel_valid_d;
    end
  end

  assign bus.pos       = pos_q;
  assign bus.dir       = dir_q;
  assign bus.err       = err_q;
  assign bus.vel       = vel_q;
  assign bus.vel_valid = vel_valid_q;

endmodule
